// File: rtl/stopwatch_lap.sv
// Stopwatch/timer core: up/down counting in hh:mm:ss.cc fields, preset load,
// prescaled centisecond tick and a first-word-fall-through lap FIFO.
module stopwatch_lap #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned TICK_HZ   = 100,
   parameter int unsigned HOURS_MAX = 99,
   parameter int unsigned LAP_DEPTH = 4,
   localparam int unsigned HW       = $clog2(HOURS_MAX + 1),
   localparam int unsigned LW       = $clog2(LAP_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sp,
   input  logic             lap,
   input  logic             clr,
   input  logic             load,
   input  logic             mode,
   input  logic [HW+11:0]   preset,
   input  logic             lap_rd,
   output logic             run,
   output logic             expired,
   output logic             wrap,
   output logic [HW-1:0]    hh,
   output logic [5:0]       mm,
   output logic [5:0]       ss,
   output logic [6:0]       cc,
   output logic [HW+18:0]   lap_data,
   output logic [LW:0]      lap_count,
   output logic             lap_ovf
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PTERM = PW'(DIV - 1);
   localparam logic [HW-1:0] HMAX  = HW'(HOURS_MAX);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   state_e        state;
   logic          mode_q;
   logic [PW-1:0] presc;

   logic          tick, time_zero;
   logic [HW-1:0] up_hh, dn_hh, pre_hh;
   logic [5:0]    up_mm, up_ss, dn_mm, dn_ss, pre_mm, pre_ss;
   logic [6:0]    up_cc, dn_cc;
   logic          up_max, dn_zero;

   // Tick strobe, zero detect and saturated preset fields
   always_comb begin
      tick      = (state == StRun) && (presc == PTERM);
      time_zero = (hh == '0) && (mm == '0) && (ss == '0) && (cc == '0);
      pre_hh    = (preset[HW+11:12] > HMAX) ? HMAX : preset[HW+11:12];
      pre_mm    = (preset[11:6] > 6'd59) ? 6'd59 : preset[11:6];
      pre_ss    = (preset[5:0] > 6'd59) ? 6'd59 : preset[5:0];
   end

   // Up-count carry chain; up_max flags the full-scale rollover
   always_comb begin
      up_hh  = hh;
      up_mm  = mm;
      up_ss  = ss;
      up_cc  = cc + 7'd1;
      up_max = 1'b0;
      if (cc == 7'd99) begin
         up_cc = '0;
         up_ss = ss + 6'd1;
         if (ss == 6'd59) begin
            up_ss = '0;
            up_mm = mm + 6'd1;
            if (mm == 6'd59) begin
               up_mm = '0;
               up_hh = hh + HW'(1);
               if (hh == HMAX) begin
                  up_hh  = '0;
                  up_max = 1'b1;
               end
            end
         end
      end
   end

   // Down-count borrow chain; never evaluated from all-zero while running
   always_comb begin
      dn_hh = hh;
      dn_mm = mm;
      dn_ss = ss;
      dn_cc = cc - 7'd1;
      if (cc == '0) begin
         dn_cc = 7'd99;
         dn_ss = ss - 6'd1;
         if (ss == '0) begin
            dn_ss = 6'd59;
            dn_mm = mm - 6'd1;
            if (mm == '0) begin
               dn_mm = 6'd59;
               dn_hh = hh - HW'(1);
            end
         end
      end
      dn_zero = (dn_hh == '0) && (dn_mm == '0) && (dn_ss == '0) && (dn_cc == '0);
   end

   // Control FSM with registered run/expired/wrap and the time fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         mode_q  <= 1'b0;
         presc   <= '0;
         run     <= 1'b0;
         expired <= 1'b0;
         wrap    <= 1'b0;
         hh      <= '0;
         mm      <= '0;
         ss      <= '0;
         cc      <= '0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            state   <= StIdle;
            presc   <= '0;
            run     <= 1'b0;
            expired <= 1'b0;
            hh      <= '0;
            mm      <= '0;
            ss      <= '0;
            cc      <= '0;
         end else if (load && (state != StRun)) begin
            state   <= StIdle;
            presc   <= '0;
            run     <= 1'b0;
            expired <= 1'b0;
            hh      <= pre_hh;
            mm      <= pre_mm;
            ss      <= pre_ss;
            cc      <= '0;
         end else begin
            unique case (state)
               StIdle, StPause: begin
                  // A countdown from zero would expire instantly, so refuse it
                  if (sp && !(mode && time_zero)) begin
                     state  <= StRun;
                     mode_q <= mode;
                     run    <= 1'b1;
                  end
               end
               StRun: begin
                  presc <= tick ? '0 : presc + PW'(1);
                  if (tick) begin
                     if (!mode_q) begin
                        hh   <= up_hh;
                        mm   <= up_mm;
                        ss   <= up_ss;
                        cc   <= up_cc;
                        wrap <= up_max;
                     end else begin
                        hh <= dn_hh;
                        mm <= dn_mm;
                        ss <= dn_ss;
                        cc <= dn_cc;
                     end
                  end
                  if (tick && mode_q && dn_zero) begin
                     state   <= StDone;
                     run     <= 1'b0;
                     expired <= 1'b1;
                  end else if (sp) begin
                     state <= StPause;
                     run   <= 1'b0;
                  end
               end
               StDone: ;
               default: state <= StIdle;
            endcase
         end
      end
   end

   logic [HW+18:0] mem [LAP_DEPTH];
   logic [LW-1:0]  wr_ptr, rd_ptr;
   logic           lap_req, full, push, pop;

   // FIFO handshake; a full FIFO still accepts a push when the head is popped
   always_comb begin
      lap_req  = lap && ((state == StRun) || (state == StPause));
      full     = (lap_count == (LW+1)'(LAP_DEPTH));
      pop      = lap_rd && (lap_count != '0) && !clr;
      push     = lap_req && (!full || pop) && !clr;
      lap_data = (lap_count == '0) ? '0 : mem[rd_ptr];
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         lap_count <= '0;
         lap_ovf   <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         lap_count <= '0;
         lap_ovf   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
         if (push && !pop)      lap_count <= lap_count + (LW+1)'(1);
         else if (pop && !push) lap_count <= lap_count - (LW+1)'(1);
         if (lap_req && full && !pop) lap_ovf <= 1'b1;
      end
   end

   // Lap storage captures the pre-tick fields
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {hh, mm, ss, cc};
   end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: directed scenarios plus a random run
// against a flat-centisecond reference model.
module tb_stopwatch_lap;
   localparam int unsigned CLK_HZ    = 1000;
   localparam int unsigned TICK_HZ   = 100;
   localparam int unsigned HOURS_MAX = 1;
   localparam int unsigned LAP_DEPTH = 4;
   localparam int HW     = $clog2(HOURS_MAX + 1);
   localparam int LW     = $clog2(LAP_DEPTH);
   localparam int DIV    = CLK_HZ / TICK_HZ;
   localparam int PERIOD = (HOURS_MAX + 1) * 360000;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

   logic clk = 0, rst = 1, sp = 0, lap = 0, clr = 0, load = 0, mode = 0, lap_rd = 0;
   logic [HW+11:0] preset = '0;
   logic run, expired, wrap, lap_ovf;
   logic [HW-1:0] hh;
   logic [5:0] mm, ss;
   logic [6:0] cc;
   logic [HW+18:0] lap_data;
   logic [LW:0] lap_count;

   int checks = 0, errors = 0;

   // Reference model state
   int m_state, m_t, m_pre;
   bit m_mode, m_wrap, m_ovf;
   int m_q[$];

   stopwatch_lap #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOURS_MAX(HOURS_MAX), .LAP_DEPTH(LAP_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .sp(sp), .lap(lap), .clr(clr), .load(load), .mode(mode),
      .preset(preset), .lap_rd(lap_rd), .run(run), .expired(expired), .wrap(wrap),
      .hh(hh), .mm(mm), .ss(ss), .cc(cc), .lap_data(lap_data), .lap_count(lap_count),
      .lap_ovf(lap_ovf)
   );

   always #5 clk = ~clk;

   function automatic int dut_t();
      return ((int'(hh) * 60 + int'(mm)) * 60 + int'(ss)) * 100 + int'(cc);
   endfunction

   function automatic logic [HW+18:0] pack(int t);
      logic [HW-1:0] h;
      logic [5:0] m, s;
      logic [6:0] c;
      h = HW'(t / 360000);
      m = 6'((t / 6000) % 60);
      s = 6'((t / 100) % 60);
      c = 7'(t % 100);
      return {h, m, s, c};
   endfunction

   function automatic int preset_t(logic [HW+11:0] p);
      int h, m, s;
      h = int'(p[HW+11:12]);
      m = int'(p[11:6]);
      s = int'(p[5:0]);
      if (h > int'(HOURS_MAX)) h = HOURS_MAX;
      if (m > 59) m = 59;
      if (s > 59) s = 59;
      return ((h * 60 + m) * 60 + s) * 100;
   endfunction

   function automatic logic [HW+11:0] mk_preset(int h, int m, int s);
      logic [HW-1:0] hv;
      logic [5:0] mv, sv;
      hv = HW'(h);
      mv = 6'(m);
      sv = 6'(s);
      return {hv, mv, sv};
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_t = 0; m_pre = 0; m_mode = 0; m_wrap = 0; m_ovf = 0;
      m_q.delete();
   endtask

   task automatic model_step(bit i_sp, bit i_lap, bit i_clr, bit i_load, bit i_mode,
                             logic [HW+11:0] i_pre, bit i_rd);
      bit full, do_pop, tick;
      m_wrap = 0;
      if (i_clr) begin
         m_q.delete();
         m_ovf = 0;
      end else begin
         full   = (m_q.size() == LAP_DEPTH);
         do_pop = i_rd && (m_q.size() > 0);
         if (do_pop) void'(m_q.pop_front());
         if (i_lap && (m_state == S_RUN || m_state == S_PAUSE)) begin
            if (!full || do_pop) m_q.push_back(m_t);
            else m_ovf = 1;
         end
      end
      if (i_clr) begin
         m_state = S_IDLE; m_t = 0; m_pre = 0;
      end else if (i_load && m_state != S_RUN) begin
         m_state = S_IDLE; m_t = preset_t(i_pre); m_pre = 0;
      end else if (m_state == S_IDLE || m_state == S_PAUSE) begin
         if (i_sp && !(i_mode && m_t == 0)) begin
            m_state = S_RUN; m_mode = i_mode;
         end
      end else if (m_state == S_RUN) begin
         tick  = (m_pre == DIV - 1);
         m_pre = tick ? 0 : m_pre + 1;
         if (tick) begin
            if (!m_mode) begin
               m_t = m_t + 1;
               if (m_t == PERIOD) begin m_t = 0; m_wrap = 1; end
            end else begin
               m_t = m_t - 1;
            end
         end
         if (tick && m_mode && m_t == 0) m_state = S_DONE;
         else if (i_sp) m_state = S_PAUSE;
      end
   endtask

   // One clock with the given strobes; returns 1 ns after the edge
   task automatic cyc(bit c_sp, bit c_lap, bit c_clr, bit c_load, bit c_mode,
                      logic [HW+11:0] c_pre, bit c_rd);
      sp = c_sp; lap = c_lap; clr = c_clr; load = c_load; mode = c_mode;
      preset = c_pre; lap_rd = c_rd;
      @(posedge clk);
      model_step(c_sp, c_lap, c_clr, c_load, c_mode, c_pre, c_rd);
      #1;
      sp = 0; lap = 0; clr = 0; load = 0; lap_rd = 0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, mode, preset, 0);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      model_reset();
      checks++;
      if ({run, expired, wrap, lap_ovf} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {run, expired, wrap, lap_ovf});
      end
      checks++;
      if ({hh, mm, ss, cc, lap_count, lap_data} !== '0) begin
         errors++;
         $display("FAIL reset_fields got t=%0d cnt=%0d data=%h want 0", dut_t(), lap_count,
                  lap_data);
      end
   endtask

   task automatic test_up_count();
      cyc(0, 0, 1, 0, 0, '0, 0);
      cyc(1, 0, 0, 0, 0, '0, 0);
      idle(1000);
      checks++;
      if (dut_t() !== 100 || run !== 1'b1) begin
         errors++;
         $display("FAIL up_1s got t=%0d run=%b want t=100 run=1", dut_t(), run);
      end
      cyc(1, 0, 0, 0, 0, '0, 0);
      idle(50);
      checks++;
      if (dut_t() !== 100 || run !== 1'b0) begin
         errors++;
         $display("FAIL up_pause got t=%0d run=%b want t=100 run=0", dut_t(), run);
      end
   endtask

   task automatic test_wrap();
      int pulses = 0;
      cyc(0, 0, 1, 0, 0, '0, 0);
      cyc(0, 0, 0, 1, 0, mk_preset(1, 59, 59), 0);
      checks++;
      if (dut_t() !== 719900) begin
         errors++;
         $display("FAIL wrap_load got t=%0d want 719900", dut_t());
      end
      cyc(1, 0, 0, 0, 0, '0, 0);
      for (int i = 0; i < 100 * DIV; i++) begin
         idle(1);
         if (wrap === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || dut_t() !== 0 || run !== 1'b1) begin
         errors++;
         $display("FAIL wrap_roll got pulses=%0d t=%0d run=%b want 1 0 1", pulses, dut_t(), run);
      end
      // Out-of-range preset fields saturate
      cyc(1, 0, 0, 0, 0, '0, 0);
      cyc(0, 0, 0, 1, 0, mk_preset(1, 63, 61), 0);
      checks++;
      if (dut_t() !== 719900) begin
         errors++;
         $display("FAIL preset_sat got t=%0d want 719900", dut_t());
      end
   endtask

   task automatic test_countdown();
      cyc(0, 0, 1, 0, 0, '0, 0);
      cyc(0, 0, 0, 1, 1, mk_preset(0, 0, 2), 0);
      cyc(1, 0, 0, 0, 1, '0, 0);
      idle(200 * DIV - 1);
      checks++;
      if (dut_t() !== 1 || expired !== 1'b0) begin
         errors++;
         $display("FAIL down_pre got t=%0d exp=%b want 1 0", dut_t(), expired);
      end
      idle(1);
      checks++;
      if (dut_t() !== 0 || expired !== 1'b1 || run !== 1'b0) begin
         errors++;
         $display("FAIL down_done got t=%0d exp=%b run=%b want 0 1 0", dut_t(), expired, run);
      end
      cyc(1, 0, 0, 0, 0, '0, 0);
      idle(30);
      checks++;
      if (expired !== 1'b1 || run !== 1'b0 || dut_t() !== 0) begin
         errors++;
         $display("FAIL done_sp got exp=%b run=%b t=%0d want 1 0 0", expired, run, dut_t());
      end
      cyc(0, 0, 1, 0, 0, '0, 0);
      checks++;
      if (expired !== 1'b0 || run !== 1'b0) begin
         errors++;
         $display("FAIL done_clr got exp=%b run=%b want 0 0", expired, run);
      end
   endtask

   task automatic test_lap_fifo();
      logic [HW+18:0] want;
      cyc(0, 0, 1, 0, 0, '0, 0);
      cyc(1, 0, 0, 0, 0, '0, 0);
      for (int n = 1; n <= 501; n++) cyc(0, (n % 100 == 1) && (n > 1), 0, 0, 0, '0, 0);
      checks++;
      if (lap_count !== 3'(4) || lap_ovf !== 1'b1) begin
         errors++;
         $display("FAIL lap_full got cnt=%0d ovf=%b want 4 1", lap_count, lap_ovf);
      end
      for (int k = 1; k <= 4; k++) begin
         want = pack(10 * k);
         checks++;
         if (lap_data !== want) begin
            errors++;
            $display("FAIL lap_pop%0d got %h want %h", k, lap_data, want);
         end
         cyc(0, 0, 0, 0, 0, '0, 1);
      end
      cyc(0, 0, 0, 0, 0, '0, 1);
      checks++;
      if (lap_count !== '0 || lap_data !== '0) begin
         errors++;
         $display("FAIL lap_empty got cnt=%0d data=%h want 0 0", lap_count, lap_data);
      end
   endtask

   task automatic test_lap_tick();
      cyc(0, 0, 1, 0, 0, '0, 0);
      cyc(1, 0, 0, 0, 0, '0, 0);
      idle(42 * DIV - 1);
      cyc(0, 1, 0, 0, 0, '0, 0);
      checks++;
      if (lap_data !== pack(41) || dut_t() !== 42 || lap_count !== 3'(1)) begin
         errors++;
         $display("FAIL lap_tick got data=%h t=%0d cnt=%0d want %h 42 1", lap_data, dut_t(),
                  lap_count, pack(41));
      end
      cyc(0, 1, 0, 0, 0, '0, 0);
      cyc(0, 1, 0, 0, 0, '0, 0);
      cyc(0, 1, 0, 0, 0, '0, 0);
      cyc(0, 1, 0, 0, 0, '0, 1);
      checks++;
      if (lap_count !== 3'(4) || lap_ovf !== 1'b0 || lap_data !== pack(42)) begin
         errors++;
         $display("FAIL lap_pushpop got cnt=%0d ovf=%b data=%h want 4 0 %h", lap_count, lap_ovf,
                  lap_data, pack(42));
      end
   endtask

   task automatic test_rst_mid();
      cyc(0, 0, 1, 0, 0, '0, 0);
      cyc(1, 0, 0, 0, 0, '0, 0);
      idle(300);
      cyc(0, 1, 0, 0, 0, '0, 0);
      idle(537 * DIV - 301);
      checks++;
      if (dut_t() !== 537 || lap_count !== 3'(1)) begin
         errors++;
         $display("FAIL rst_pre got t=%0d cnt=%0d want 537 1", dut_t(), lap_count);
      end
      #2 rst = 1;
      #1;
      checks++;
      if ({run, expired, wrap, lap_ovf, hh, mm, ss, cc, lap_count, lap_data} !== '0) begin
         errors++;
         $display("FAIL rst_mid got run=%b t=%0d cnt=%0d want 0", run, dut_t(), lap_count);
      end
      model_reset();
      @(posedge clk);
      #3 rst = 0;
      cyc(1, 0, 0, 0, 1, '0, 0);
      idle(20);
      checks++;
      if (run !== 1'b0 || dut_t() !== 0) begin
         errors++;
         $display("FAIL down_zero_sp got run=%b t=%0d want 0 0", run, dut_t());
      end
   endtask

   task automatic test_random();
      bit r_sp, r_lap, r_clr, r_load, r_rd, r_mode;
      logic [HW+11:0] r_pre;
      int h, m, s;
      logic [HW+18:0] want;
      r_mode = 0;
      for (int i = 0; i < 6000; i++) begin
         r_sp   = ($urandom_range(0, 99) < 3);
         r_lap  = ($urandom_range(0, 99) < 8);
         r_clr  = ($urandom_range(0, 999) < 4);
         r_load = ($urandom_range(0, 99) < 2);
         r_rd   = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
         h = $urandom_range(0, 1);
         m = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 63);
         s = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1) : $urandom_range(0, 63);
         if ($urandom_range(0, 2) != 0) h = 0;
         r_pre = mk_preset(h, m, s);
         cyc(r_sp, r_lap, r_clr, r_load, r_mode, r_pre, r_rd);
         checks++;
         if (dut_t() !== m_t) begin
            errors++;
            $display("FAIL rnd_time cyc %0d got %0d want %0d", i, dut_t(), m_t);
         end
         checks++;
         if ({run, expired, wrap, lap_ovf} !== {m_state == S_RUN, m_state == S_DONE, m_wrap, m_ovf})
         begin
            errors++;
            $display("FAIL rnd_flags cyc %0d got %b want %b", i, {run, expired, wrap, lap_ovf},
                     {m_state == S_RUN, m_state == S_DONE, m_wrap, m_ovf});
         end
         want = (m_q.size() > 0) ? pack(m_q[0]) : '0;
         checks++;
         if (int'(lap_count) != m_q.size() || lap_data !== want) begin
            errors++;
            $display("FAIL rnd_lap cyc %0d got cnt=%0d data=%h want %0d %h", i, lap_count,
                     lap_data, m_q.size(), want);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_up_count();
      test_wrap();
      test_countdown();
      test_lap_fifo();
      test_lap_tick();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
